// File: rtl/uart_out_port.sv
// CPU output port: buffers 16-bit words in a small FIFO and sends each one over an 8N1 UART line,
// low byte first and then high byte; a push that finds the FIFO full is dropped and sets sticky overflow.
module uart_out_port #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] out_port,
   input  logic        output_valid,
   input  logic        ovf_clr,
   output logic        tx,
   output logic        busy,
   output logic        fifo_full,
   output logic        overflow
);

   localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic [15:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [COUNT_W-1:0] count_reg;

   state_t             state_reg;
   logic [BAUD_W-1:0]  baud_reg;
   logic [2:0]         bit_idx_reg;
   logic               byte_sel_reg;
   logic [15:0]        hold_reg;
   logic               tx_reg;
   logic               busy_reg;
   logic               overflow_reg;

   logic               push;
   logic               pop;
   logic               baud_done;
   logic [7:0]         cur_byte;

   // Full is judged from the pre-edge count, so a pop in the same cycle never rescues a push.
   assign fifo_full = (count_reg == FULL_COUNT);
   assign push      = output_valid && !fifo_full;
   assign pop       = (state_reg == IDLE) && (count_reg != '0);
   assign baud_done = (baud_reg == BAUD_LAST);
   assign cur_byte  = byte_sel_reg ? hold_reg[15:8] : hold_reg[7:0];

   assign tx       = tx_reg;
   assign busy     = busy_reg;
   assign overflow = overflow_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= out_port;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + COUNT_W'(1);
            2'b01:   count_reg <= count_reg - COUNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Set beats clear when a dropped push and ovf_clr coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_reg <= 1'b0;
      end else if (output_valid && fifo_full) begin
         overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
         overflow_reg <= 1'b0;
      end
   end

   // tx_reg is loaded with the level of the state being entered, so the line never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         baud_reg     <= '0;
         bit_idx_reg  <= '0;
         byte_sel_reg <= 1'b0;
         hold_reg     <= '0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               tx_reg   <= 1'b1;
               baud_reg <= '0;
               if (pop) begin
                  hold_reg     <= mem[rd_ptr_reg];
                  byte_sel_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  tx_reg       <= 1'b0;
                  state_reg    <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_reg    <= '0;
                  bit_idx_reg <= '0;
                  tx_reg      <= cur_byte[0];
                  state_reg   <= DATA;
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_reg <= '0;
                  if (bit_idx_reg == 3'd7) begin
                     tx_reg    <= 1'b1;
                     state_reg <= STOP;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                     tx_reg      <= cur_byte[bit_idx_reg + 3'd1];
                  end
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_reg <= '0;
                  if (!byte_sel_reg) begin
                     byte_sel_reg <= 1'b1;
                     tx_reg       <= 1'b0;
                     state_reg    <= START;
                  end else begin
                     busy_reg  <= 1'b0;
                     tx_reg    <= 1'b1;
                     state_reg <= IDLE;
                  end
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               tx_reg    <= 1'b1;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_out_port.sv
// Directed bench for uart_out_port at CLKS_PER_BIT=4, FIFO_DEPTH=8; a negedge monitor decodes tx frames.
module tb_uart_out_port;

   logic        clk;
   logic        rst_n;
   logic [15:0] out_port;
   logic        output_valid;
   logic        ovf_clr;
   logic        tx;
   logic        busy;
   logic        fifo_full;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] rx_q[$];
   int         mon_starts[$];
   int         width_err = 0;
   int         stop_err  = 0;
   bit         mon_active = 0;
   int         mon_cnt   = 0;
   logic       mon_first = 1'b1;
   logic [7:0] mon_byte  = 8'h00;

   uart_out_port #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .out_port(out_port),
      .output_valid(output_valid),
      .ovf_clr(ovf_clr),
      .tx(tx),
      .busy(busy),
      .fifo_full(fifo_full),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame decoder: 40 negedge samples per frame, every 4-sample bit must be constant.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active = 0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1;
            mon_cnt    = 0;
            mon_first  = 1'b0;
            mon_byte   = 8'h00;
            mon_starts.push_back(cyc);
         end
      end else begin
         mon_cnt = mon_cnt + 1;
         if (mon_cnt % 4 == 0) begin
            mon_first = tx;
            if (mon_cnt / 4 >= 1 && mon_cnt / 4 <= 8) mon_byte[mon_cnt / 4 - 1] = tx;
            if (mon_cnt / 4 == 9 && tx !== 1'b1) stop_err = stop_err + 1;
         end else if (tx !== mon_first) begin
            width_err = width_err + 1;
         end
         if (mon_cnt == 39) begin
            rx_q.push_back(mon_byte);
            mon_active = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 500000");
      $fatal(1, "watchdog");
   end

   task automatic wait_rx(input int n, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rx_q.size() >= n) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic clear_mon();
      rx_q.delete();
      mon_starts.delete();
      width_err = 0;
      stop_err  = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      out_port = 16'h0000;
      output_valid = 1'b0;
      ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: tx=%b busy=%b want 1/0", tx, busy); end
      $display("test_reset: tx=%b busy=%b full=%b ovf=%b", tx, busy, fifo_full, overflow);
   endtask

   task automatic test_single();
      int bc;
      clear_mon();
      @(negedge clk);
      out_port = 16'hA55A;
      output_valid = 1'b1;
      @(negedge clk);
      output_valid = 1'b0;
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_pre_pop: tx=%b busy=%b want 1/0", tx, busy); end
      @(negedge clk);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_tx_fall: got %b want 0", tx); end
      bc = 0;
      for (int i = 0; i < 200; i++) begin
         if (busy === 1'b1) bc++;
         else break;
         @(negedge clk);
      end
      checks++; if (bc !== 80) begin errors++; $display("FAIL single_busy_len: got %0d want 80", bc); end
      checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL single_nbytes: got %0d want 2", rx_q.size()); end
      checks++; if (rx_q[0] !== 8'h5A) begin errors++; $display("FAIL single_byte0: got %h want 5a", rx_q[0]); end
      checks++; if (rx_q[1] !== 8'hA5) begin errors++; $display("FAIL single_byte1: got %h want a5", rx_q[1]); end
      checks++; if (stop_err !== 0 || width_err !== 0) begin errors++; $display("FAIL single_framing: stop_err=%0d width_err=%0d want 0/0", stop_err, width_err); end
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_empty: busy=%b tx=%b want 0/1", busy, tx); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b want 0", overflow); end
      $display("test_single: busy_cycles=%0d bytes=%h %h", bc, rx_q[0], rx_q[1]);
   endtask

   task automatic test_burst();
      bit ok;
      logic [15:0] w;
      clear_mon();
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 9) begin
            checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL burst_full_w8: got %b want 0", fifo_full); end
         end
         if (i == 10) begin
            checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL burst_full_w9: got %b want 1", fifo_full); end
         end
         out_port = 16'(i);
         output_valid = 1'b1;
      end
      @(negedge clk);
      output_valid = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_ovf: got %b want 1", overflow); end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL burst_full_after: got %b want 1", fifo_full); end
      wait_rx(18, 2000, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL burst_timeout: got %0d bytes want 18", rx_q.size()); end
      for (int k = 0; k < 9; k++) begin
         w = {rx_q[2*k+1], rx_q[2*k]};
         checks++; if (w !== 16'(k + 1)) begin errors++; $display("FAIL burst_word%0d: got %h want %h", k, w, 16'(k + 1)); end
      end
      wait_idle(200, ok);
      repeat (100) @(negedge clk);
      checks++; if (rx_q.size() !== 18) begin errors++; $display("FAIL burst_extra: got %0d bytes want 18", rx_q.size()); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_ovf_sticky: got %b want 1", overflow); end
      $display("test_burst: bytes=%0d ovf=%b", rx_q.size(), overflow);
   endtask

   task automatic test_ovf_clr();
      bit ok;
      logic [15:0] w;
      clear_mon();
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovfclr_idle: got %b want 0", overflow); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         out_port = 16'h0100 + 16'(i);
         output_valid = 1'b1;
         ovf_clr = (i == 9);
      end
      @(negedge clk);
      output_valid = 1'b0;
      ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovfclr_set_wins: got %b want 1", overflow); end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovfclr_busy: got %b want 0", overflow); end
      wait_rx(18, 2000, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovfclr_timeout: got %0d bytes want 18", rx_q.size()); end
      for (int k = 0; k < 9; k++) begin
         w = {rx_q[2*k+1], rx_q[2*k]};
         checks++; if (w !== 16'h0100 + 16'(k)) begin errors++; $display("FAIL ovfclr_word%0d: got %h want %h", k, w, 16'h0100 + 16'(k)); end
      end
      wait_idle(200, ok);
      $display("test_ovf_clr: bytes=%0d ovf=%b", rx_q.size(), overflow);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int bad;
      logic [15:0] words [4];
      words[0] = 16'h1234;
      words[1] = 16'h0002;
      words[2] = 16'h0003;
      words[3] = 16'h0004;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         out_port = words[i];
         output_valid = 1'b1;
      end
      @(negedge clk);
      output_valid = 1'b0;
      repeat (6) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      checks++; if (fifo_full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_flags: full=%b ovf=%b want 0/0", fifo_full, overflow); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet: active samples=%0d want 0", bad); end
      checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rstmid_nobytes: got %0d want 0", rx_q.size()); end
      @(negedge clk);
      out_port = 16'h00C3;
      output_valid = 1'b1;
      @(negedge clk);
      output_valid = 1'b0;
      wait_rx(2, 200, ok);
      checks++; if ({rx_q[1], rx_q[0]} !== 16'h00C3) begin errors++; $display("FAIL rstmid_newword: got %h want 00c3", {rx_q[1], rx_q[0]}); end
      wait_idle(200, ok);
      repeat (10) @(negedge clk);
      checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL rstmid_only_new: got %0d bytes want 2", rx_q.size()); end
      $display("test_reset_mid: quiet_bad=%0d new_bytes=%0d", bad, rx_q.size());
   endtask

   task automatic test_push_pop();
      bit ok;
      logic [15:0] exp_w [10];
      logic [15:0] w;
      clear_mon();
      exp_w[0] = 16'h1111;
      for (int k = 1; k <= 7; k++) exp_w[k] = 16'h2000 + 16'(k);
      exp_w[8] = 16'h3333;
      exp_w[9] = 16'h4444;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         out_port = exp_w[i];
         output_valid = 1'b1;
      end
      @(negedge clk);
      output_valid = 1'b0;
      wait_idle(200, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pushpop_idle_timeout: busy=%b want 0", busy); end
      out_port = exp_w[8];
      output_valid = 1'b1;
      @(negedge clk);
      out_port = exp_w[9];
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pushpop_popped: busy=%b want 1", busy); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL pushpop_count_same: full=%b want 0", fifo_full); end
      @(negedge clk);
      output_valid = 1'b0;
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL pushpop_fill: full=%b want 1", fifo_full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_ovf: got %b want 0", overflow); end
      wait_rx(20, 3000, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pushpop_timeout: got %0d bytes want 20", rx_q.size()); end
      for (int k = 0; k < 10; k++) begin
         w = {rx_q[2*k+1], rx_q[2*k]};
         checks++; if (w !== exp_w[k]) begin errors++; $display("FAIL pushpop_word%0d: got %h want %h", k, w, exp_w[k]); end
      end
      wait_idle(200, ok);
      $display("test_push_pop: bytes=%0d ovf=%b", rx_q.size(), overflow);
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_mon();
      @(negedge clk);
      out_port = 16'hFF00;
      output_valid = 1'b1;
      @(negedge clk);
      out_port = 16'h00FF;
      @(negedge clk);
      output_valid = 1'b0;
      wait_rx(4, 400, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout: got %0d bytes want 4", rx_q.size()); end
      checks++; if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'h00FF_FF00) begin
         errors++; $display("FAIL b2b_bytes: got %h %h %h %h want 00 ff ff 00", rx_q[0], rx_q[1], rx_q[2], rx_q[3]);
      end
      checks++; if (mon_starts[1] - mon_starts[0] !== 40) begin errors++; $display("FAIL b2b_byte_gap: got %0d want 40", mon_starts[1] - mon_starts[0]); end
      checks++; if (mon_starts[2] - mon_starts[1] !== 41) begin errors++; $display("FAIL b2b_word_gap: got %0d want 41", mon_starts[2] - mon_starts[1]); end
      checks++; if (mon_starts[3] - mon_starts[2] !== 40) begin errors++; $display("FAIL b2b_byte_gap2: got %0d want 40", mon_starts[3] - mon_starts[2]); end
      checks++; if (width_err !== 0 || stop_err !== 0) begin errors++; $display("FAIL b2b_framing: width_err=%0d stop_err=%0d want 0/0", width_err, stop_err); end
      wait_idle(200, ok);
      $display("test_back_to_back: starts=%0d,%0d,%0d,%0d", mon_starts[0], mon_starts[1], mon_starts[2], mon_starts[3]);
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_ovf_clr();
      test_reset_mid();
      test_push_pop();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
